// File: rtl/attn_pkg.sv
// Shared constants and state type for the attention output collector.
package attn_pkg;

  localparam int unsigned ATTN_ROWS   = 4;
  localparam int unsigned ATTN_GROUPS = 32;
  localparam int unsigned OUT_WORDS   = ATTN_ROWS * ATTN_GROUPS;
  localparam int unsigned OUT_ADDR_W  = 7;
  localparam int unsigned WORD_W      = 128;
  localparam int unsigned COUNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_COMPLETE = 2'd2
  } collect_state_t;

  // Output-SRAM word address of a beat: group in the high bits, row in the low bits.
  function automatic logic [OUT_ADDR_W-1:0] out_addr(input logic [4:0] group,
                                                     input logic [1:0] row);
    return {group, row};
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit delay line; tracks which SRAM read cycles return data.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/attn_out_collector.sv
// Collects the 128-word attention output stream into the output SRAM, tracks
// coverage with a bitmap, and serves host reads through the same SRAM port.
module attn_out_collector
  import attn_pkg::*;
#(
  parameter int unsigned READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  in_valid,
  input  logic [1:0]            in_row,
  input  logic [4:0]            in_group,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_done,
  output logic [OUT_ADDR_W-1:0] O_mem_addr,
  output logic                  O_mem_wen,
  output logic [WORD_W-1:0]     O_mem_in,
  output logic                  O_mem_ren,
  input  logic [WORD_W-1:0]     O_mem_out,
  input  logic                  rd_req,
  input  logic [OUT_ADDR_W-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [WORD_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  complete,
  output logic                  dup_err,
  output logic                  missing_err,
  output logic                  stray_err,
  output logic [COUNT_W-1:0]    word_count
);

  collect_state_t         state;
  logic [OUT_WORDS-1:0]   bitmap;
  logic                   in_collect;
  logic                   beat_wr;
  logic                   rd_accept;
  logic [OUT_ADDR_W-1:0]  beat_addr;
  logic                   beat_new;
  logic [COUNT_W-1:0]     count_next;

  // A collecting beat owns the SRAM port, so reads are refused that cycle;
  // this is what keeps write and read enables mutually exclusive.
  always_comb begin
    in_collect = (state == ST_COLLECT);
    beat_wr    = in_valid & in_collect & ~arm;
    rd_ready   = ~(in_valid & in_collect) & ~arm;
    rd_accept  = rd_req & rd_ready;
    beat_addr  = out_addr(in_group, in_row);
    beat_new   = ~bitmap[beat_addr];
    count_next = word_count + COUNT_W'(beat_new);
    busy       = in_collect;
    complete   = (state == ST_COMPLETE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O_mem_wen  <= 1'b0;
      O_mem_ren  <= 1'b0;
      O_mem_addr <= '0;
      O_mem_in   <= '0;
    end else begin
      O_mem_wen <= beat_wr;
      O_mem_ren <= rd_accept;
      if (beat_wr) begin
        O_mem_addr <= beat_addr;
        O_mem_in   <= in_data;
      end else if (rd_accept) begin
        O_mem_addr <= rd_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bitmap      <= '0;
      word_count  <= '0;
      dup_err     <= 1'b0;
      missing_err <= 1'b0;
      stray_err   <= 1'b0;
    end else if (arm) begin
      state       <= ST_COLLECT;
      bitmap      <= '0;
      word_count  <= '0;
      dup_err     <= 1'b0;
      missing_err <= 1'b0;
      stray_err   <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (beat_wr) begin
            bitmap[beat_addr] <= 1'b1;
            word_count        <= count_next;
            if (!beat_new) dup_err <= 1'b1;
          end
          // A beat completing the set wins over a same-cycle in_done: no missing flag.
          if (beat_wr && count_next == COUNT_W'(OUT_WORDS)) begin
            state <= ST_COMPLETE;
          end else if (in_done) begin
            state       <= ST_COMPLETE;
            missing_err <= 1'b1;
          end
        end
        default: begin
          if (in_valid) stray_err <= 1'b1;
        end
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH(READ_LAT)
  ) u_rd_delay (
    .clk (clk),
    .rst (rst),
    .din (O_mem_ren),
    .dout(rd_valid)
  );

  assign rd_data = rd_valid ? O_mem_out : '0;

endmodule

// File: tb/tb_attn_out_collector.sv
// Directed bench for attn_out_collector with a queue-based reference model and SRAM model.
module tb_attn_out_collector;
  import attn_pkg::*;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         arm = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_row = '0;
  logic [4:0]   in_group = '0;
  logic [127:0] in_data = '0;
  logic         in_done = 1'b0;
  logic         rd_req = 1'b0;
  logic [6:0]   rd_addr = '0;

  logic [6:0]   O_mem_addr;
  logic         O_mem_wen, O_mem_ren;
  logic [127:0] O_mem_in, O_mem_out, rd_data;
  logic         rd_ready, rd_valid, busy, complete, dup_err, missing_err, stray_err;
  logic [7:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  attn_out_collector #(.READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_row(in_row),
    .in_group(in_group), .in_data(in_data), .in_done(in_done),
    .O_mem_addr(O_mem_addr), .O_mem_wen(O_mem_wen), .O_mem_in(O_mem_in),
    .O_mem_ren(O_mem_ren), .O_mem_out(O_mem_out), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .complete(complete), .dup_err(dup_err),
    .missing_err(missing_err), .stray_err(stray_err), .word_count(word_count)
  );

  // SRAM model: data visible LAT cycles after the cycle O_mem_ren is high.
  logic [127:0] mem [128];
  logic [127:0] rpipe [LAT];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;
  end
  always @(posedge clk) begin
    if (O_mem_wen) mem[O_mem_addr] <= O_mem_in;
    rpipe[0] <= O_mem_ren ? mem[O_mem_addr] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign O_mem_out = rpipe[LAT-1];

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] pat(input int a, input int s);
    return {32'(a + 3 + s), 32'(a + 2 + s), 32'(a + 1 + s), 32'(a + s)};
  endfunction

  // Reference model: phase 0=idle 1=collecting 2=complete; reads kept as a
  // queue of (due cycle, data) entries.
  typedef struct {
    int           due;
    logic [127:0] data;
  } rd_t;

  int           phase = 0;
  bit           seen [128];
  int           cnt = 0;
  bit           m_dup = 0, m_miss = 0, m_stray = 0;
  bit           e_wen = 0, e_ren = 0;
  logic [6:0]   e_addr = '0;
  logic [127:0] e_in = '0;
  logic [127:0] gold [128];
  int           cyc = 0;
  rd_t          rq [$];

  initial for (int i = 0; i < 128; i++) begin gold[i] = '0; seen[i] = 0; end

  task automatic model_step();
    int  a;
    rd_t r;
    if (rst) begin
      phase = 0; cnt = 0; m_dup = 0; m_miss = 0; m_stray = 0;
      e_wen = 0; e_ren = 0; e_addr = '0; e_in = '0;
      for (int i = 0; i < 128; i++) seen[i] = 0;
      rq.delete();
      cyc++;
    end else begin
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      cyc++;
      e_wen = 0; e_ren = 0;
      if (arm) begin
        phase = 1; cnt = 0; m_dup = 0; m_miss = 0; m_stray = 0;
        for (int i = 0; i < 128; i++) seen[i] = 0;
      end else begin
        a = int'({in_group, in_row});
        if (in_valid && phase == 1) begin
          e_wen = 1; e_addr = 7'(a); e_in = in_data; gold[a] = in_data;
          if (seen[a]) m_dup = 1;
          else begin seen[a] = 1; cnt++; end
        end else begin
          if (in_valid) m_stray = 1;
          if (rd_req) begin
            e_ren = 1; e_addr = rd_addr;
            r.due = cyc + LAT; r.data = gold[rd_addr];
            rq.push_back(r);
          end
        end
        if (phase == 1) begin
          if (cnt == 128) phase = 2;
          else if (in_done) begin phase = 2; m_miss = 1; end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    bit           ev;
    logic [127:0] ed;
    @(negedge clk);
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    ed = ev ? rq[0].data : '0;
    check("busy", busy, phase == 1);
    check("complete", complete, phase == 2);
    check("word_count", word_count, cnt);
    check("dup_err", dup_err, m_dup);
    check("missing_err", missing_err, m_miss);
    check("stray_err", stray_err, m_stray);
    check("wen", O_mem_wen, e_wen);
    check("ren", O_mem_ren, e_ren);
    check("addr", O_mem_addr, e_addr);
    check("wdata", O_mem_in, e_in);
    check("rd_ready", rd_ready, !(in_valid && phase == 1) && !arm);
    check("rd_valid", rd_valid, ev);
    check("rd_data", rd_data, ed);
    check("wen_ren_excl", O_mem_wen & O_mem_ren, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input logic [127:0] d);
    logic [6:0] ad;
    ad = 7'(a);
    in_valid = 1'b1; in_group = ad[6:2]; in_row = ad[1:0]; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_arm();
    tick(); arm = 1'b1; tick(); arm = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(); tick();
    @(negedge clk);
    check("lit_rst_count", word_count, 8'd0);
    check("lit_rst_busy", busy, 1'b0);
    check("lit_rst_addr", O_mem_addr, 7'd0);
    tick(); rst = 1'b0;

    // Stray beat while idle, then arm with a discarded same-cycle beat
    tick();
    beat(3, pat(3, 'h100));
    @(negedge clk);
    check("lit_stray_set", stray_err, 1'b1);
    check("lit_stray_nowen", O_mem_wen, 1'b0);
    tick();
    arm = 1'b1; in_valid = 1'b1; in_group = 5'd2; in_row = 2'd1; in_data = pat(9, 0);
    tick();
    arm = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("lit_arm_stray_clr", stray_err, 1'b0);
    check("lit_arm_count", word_count, 8'd0);
    check("lit_arm_nowen", O_mem_wen, 1'b0);
    check("lit_arm_busy", busy, 1'b1);

    // Full in-order collection
    tick();
    for (int a = 0; a < 128; a++) beat(a, pat(a, 0));
    @(negedge clk);
    check("lit_full_complete", complete, 1'b1);
    check("lit_full_count", word_count, 8'd128);
    check("lit_full_err", {dup_err, missing_err, stray_err}, 3'b000);

    // Held read of 0x2A while complete
    tick();
    rd_addr = 7'h2A; rd_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 3) rd_req = 1'b0;
      @(negedge clk);
      check("lit_held_rd_valid", rd_valid, (k >= 3 && k <= 5));
      if (k >= 3 && k <= 5)
        check("lit_held_rd_data", rd_data, 128'h0000002D_0000002C_0000002B_0000002A);
    end

    // Read colliding with a beat while collecting
    do_arm();
    in_valid = 1'b1; in_group = 5'd4; in_row = 2'd0; in_data = pat(16, 'h500);
    rd_req = 1'b1; rd_addr = 7'h10;
    @(negedge clk);
    check("lit_collide_ready", rd_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_collide_ready2", rd_ready, 1'b1);
    check("lit_collide_wen", O_mem_wen, 1'b1);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("lit_collide_ren", O_mem_ren, 1'b1);
    tick(); tick();

    // 127 unique beats, overwrite of address 5, then in_done
    do_arm();
    for (int a = 0; a < 127; a++) beat(a, pat(a, 0));
    beat(5, pat(5, 'h77));
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    @(negedge clk);
    check("lit_miss_flag", missing_err, 1'b1);
    check("lit_dup_flag", dup_err, 1'b1);
    check("lit_miss_count", word_count, 8'd127);
    check("lit_miss_complete", complete, 1'b1);
    tick();
    rd_req = 1'b1; rd_addr = 7'd5;
    tick();
    rd_req = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("lit_ovw_valid", rd_valid, 1'b1);
    check("lit_ovw_data", rd_data, 128'h0000007F_0000007E_0000007D_0000007C);

    // Reset with reads in flight after 60 words
    do_arm();
    for (int a = 0; a < 60; a++) beat(a, pat(a, 3));
    rd_req = 1'b1; rd_addr = 7'd7;
    tick();
    rd_addr = 7'd8;
    tick();
    rd_req = 1'b0;
    #2 rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("lit_rst2_count", word_count, 8'd0);
    check("lit_rst2_state", {busy, complete}, 2'b00);
    check("lit_rst2_addr", O_mem_addr, 7'd0);
    check("lit_rst2_wdata", O_mem_in, 128'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lit_rst2_no_rd_valid", rd_valid, 1'b0);
      check("lit_rst2_idle", busy, 1'b0);
      tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/attn_out_collector.md
ATTN_OUT_COLLECTOR -- requirements
Module: attn_out_collector

Interface
REQ-001 SHALL have parameter READ_LAT, default 2, meaning output-SRAM read latency in cycles from O_mem_ren to valid O_mem_out.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 arm  input  1  start/restart a collection (level sampled per cycle).
REQ-005 in_valid  input  1  output-stream beat valid; no backpressure exists.
REQ-006 in_row  input  2  row index 0..3 of the beat.
REQ-007 in_group  input  5  group index 0..31, {head, tile}.
REQ-008 in_data  input  128  four fp32 lanes, lane 0 in bits [31:0].
REQ-009 in_done  input  1  producer end-of-run pulse.
REQ-010 O_mem_addr  output  7  output-SRAM address.
REQ-011 O_mem_wen  output  1  output-SRAM write enable.
REQ-012 O_mem_in  output  128  output-SRAM write data.
REQ-013 O_mem_ren  output  1  output-SRAM read enable.
REQ-014 O_mem_out  input  128  output-SRAM read data.
REQ-015 rd_req  input  1  host read request.
REQ-016 rd_addr  input  7  host read address.
REQ-017 rd_ready  output  1  host read accepted this cycle when rd_req=1.
REQ-018 rd_valid  output  1  rd_data valid (one cycle per accepted read).
REQ-019 rd_data  output  128  host read data.
REQ-020 busy, complete, dup_err, missing_err, stray_err  output  1 each  status (see Function).
REQ-021 word_count  output  8  unique words received, 0..128.

Function
REQ-022 States IDLE, COLLECT, COMPLETE; busy=1 only in COLLECT; complete=1 only in COMPLETE.
REQ-023 arm=1 in any state -> next state COLLECT, bitmap, word_count and all error flags cleared; arm has priority over every same-cycle event and a same-cycle in_valid beat is discarded with no write and no flag.
REQ-024 In COLLECT, in_valid beat -> next cycle O_mem_wen=1, O_mem_addr={in_group,in_row}, O_mem_in=in_data (one-cycle write latency, registered).
REQ-025 Beat to an address whose bitmap bit is clear -> bit set, word_count+1; bit already set -> data still written (overwrite), dup_err set sticky, word_count unchanged.
REQ-026 word_count reaching 128 -> COMPLETE on the same edge; complete asserted the cycle after the 128th unique beat.
REQ-027 in_done in COLLECT with word_count<128 (after counting any same-cycle beat) -> COMPLETE with missing_err sticky; in_done in other states ignored.
REQ-028 in_valid in IDLE or COMPLETE -> no write, stray_err sticky.
REQ-029 rd_ready = ~(in_valid & state==COLLECT) & ~arm (combinational); host reads allowed in every state.
REQ-030 Accepted read -> next cycle O_mem_ren=1, O_mem_addr=rd_addr; rd_valid=1 and rd_data=O_mem_out exactly READ_LAT cycles after O_mem_ren, i.e. READ_LAT+1 cycles after acceptance; back-to-back accepted reads return back-to-back, in order.
REQ-031 O_mem_wen and O_mem_ren never both 1 in one cycle.
REQ-032 Idle SRAM outputs: wen=0, ren=0; addr and write data hold last value.

Reset
REQ-033 rst=1 -> state IDLE, all 1-bit outputs 0, word_count=0, bitmap cleared, O_mem_addr=0, O_mem_in=0, rd_data=0, read-latency pipeline valid bits cleared; in-flight reads produce no rd_valid.
REQ-034 Reset mid-COLLECT discards collection; a new arm is required.

Structure
REQ-035 Shared package attn_pkg holds ATTN_ROWS=4, ATTN_GROUPS=32, OUT_WORDS=128, OUT_ADDR_W=7, and the collector state enum.
REQ-036 One sub-module, valid_delay_line (parameter depth READ_LAT, 1-bit, async active-high reset), implements the read-return timing; bitmap and FSM stay in the top.

Verification
REQ-037 arm, then 128 beats in order group 0..31 x row 0..3, data=addr pattern -> 128 writes at addr {g,r}, word_count=128, complete=1 the cycle after last beat, no error flags.
REQ-038 arm, 127 unique beats plus repeat of addr 5 with new data, then in_done -> missing_err=1, dup_err=1, word_count=127, addr 5 holds new data.
REQ-039 COMPLETE, rd_req with rd_addr=0x2A held 3 cycles -> three rd_valid pulses at cycles 3,4,5 after first acceptance (READ_LAT=2), rd_data = stored word 0x2A.
REQ-040 COLLECT, rd_req and in_valid same cycle -> rd_ready=0, write performed, read accepted next cycle without in_valid.
REQ-041 in_valid while IDLE -> stray_err=1, no O_mem_wen; then arm with in_valid same cycle -> flags cleared, no write, word_count=0.
REQ-042 rst asserted with reads in flight and 60 words collected -> no rd_valid afterwards, all outputs at reset values, state IDLE.
